// File: rtl/free_list_if.sv
// Rename/commit side of the physical-register free list.
// The master drives allocations and returns. The slave is the free list itself.
interface free_list_if #(
    parameter int ID_WIDTH = 2,
    parameter int PRF_IDX  = 6
);
    logic [ID_WIDTH-1:0]              id_valid;
    logic                             id_ready;
    logic [ID_WIDTH-1:0][PRF_IDX-1:0] free_idx;
    logic [ID_WIDTH-1:0]              rrf_valid;
    logic [ID_WIDTH-1:0][PRF_IDX-1:0] stale_idx;
    logic                             flush;

    modport master (
        output id_valid, rrf_valid, stale_idx, flush,
        input  id_ready, free_idx
    );

    modport slave (
        input  id_valid, rrf_valid, stale_idx, flush,
        output id_ready, free_idx
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register indices with multi-lane allocate/return.
// A flush reclaims every non-architectural register.
module free_list #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int ID_WIDTH  = 2
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);
    localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH;
    localparam int PRF_IDX  = $clog2(PRF_DEPTH);
    localparam int FL_IDX   = $clog2(FL_DEPTH);
    localparam int PTR_W    = FL_IDX + 1;

    logic [PRF_IDX-1:0] mem_q [FL_DEPTH];
    logic [PRF_IDX-1:0] mem_d [FL_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   count;
    logic [PTR_W-1:0]   enq_cnt;
    logic [PTR_W-1:0]   deq_cnt;
    logic [PTR_W:0]     count_next;
    logic               id_ready;

    assign count       = tail_q - head_q;
    assign id_ready    = (count >= PTR_W'(ID_WIDTH));
    assign fl.id_ready = id_ready;

    for (genvar gi = 0; gi < ID_WIDTH; gi++) begin : g_rd
        assign fl.free_idx[gi] = mem_q[FL_IDX'(head_q[FL_IDX-1:0] + FL_IDX'(gi))];
    end

    always_comb begin
        enq_cnt = '0;
        deq_cnt = '0;
        mem_d   = mem_q;
        // Valid return lanes are packed into consecutive slots starting at tail.
        for (int i = 0; i < ID_WIDTH; i++) begin
            if (fl.rrf_valid[i]) begin
                mem_d[FL_IDX'(tail_q[FL_IDX-1:0] + enq_cnt[FL_IDX-1:0])] = fl.stale_idx[i];
                enq_cnt = enq_cnt + PTR_W'(1);
            end
            if (fl.id_valid[i]) begin
                deq_cnt = deq_cnt + PTR_W'(1);
            end
        end
        if (!id_ready || fl.flush) begin
            deq_cnt = '0;
        end
        tail_d = tail_q + enq_cnt;
        // Inverting the wrap bit makes the list read as exactly full.
        head_d = fl.flush ? {~tail_d[FL_IDX], tail_d[FL_IDX-1:0]} : head_q + deq_cnt;
    end

    assign count_next = {1'b0, count} + {1'b0, enq_cnt} - {1'b0, deq_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PRF_IDX'(ARF_DEPTH + i);
            end
            head_q <= '0;
            tail_q <= {1'b1, {FL_IDX{1'b0}}};
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    a_prefix_lanes: assert property (@(posedge clk) disable iff (rst)
        ((fl.id_valid & (fl.id_valid + ID_WIDTH'(1))) == '0));

    a_alloc_when_ready: assert property (@(posedge clk) disable iff (rst)
        (fl.flush || fl.id_valid == '0 || id_ready));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (fl.flush || count_next <= (PTR_W+1)'(FL_DEPTH)));
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, drain, refill, concurrent traffic, flush, wrap, reset priority.
module tb_free_list;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    free_list_if #(.ID_WIDTH(2), .PRF_IDX(6)) fl ();

    free_list #(.PRF_DEPTH(64), .ARF_DEPTH(32), .ID_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fl.id_valid  = '0;
        fl.rrf_valid = '0;
        fl.stale_idx = '0;
        fl.flush     = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] e0, e1;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e0 = 6'd32;
        e1 = 6'd33;
        checks++;
        if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", fl.id_ready); end
        checks++;
        if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL reset_idx0: got %0d expected %0d", fl.free_idx[0], e0); end
        checks++;
        if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL reset_idx1: got %0d expected %0d", fl.free_idx[1], e1); end
        $display("test_reset: ready=%0b idx={%0d,%0d}", fl.id_ready, fl.free_idx[0], fl.free_idx[1]);
    endtask

    task automatic test_drain(input string name);
        logic [5:0] e0, e1;
        fl.id_valid = 2'b11;
        for (int c = 0; c < 16; c++) begin
            e0 = 6'(32 + 2 * c);
            e1 = 6'(33 + 2 * c);
            checks++;
            if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL %s_ready c=%0d: got %0b expected 1", name, c, fl.id_ready); end
            checks++;
            if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL %s_idx0 c=%0d: got %0d expected %0d", name, c, fl.free_idx[0], e0); end
            checks++;
            if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL %s_idx1 c=%0d: got %0d expected %0d", name, c, fl.free_idx[1], e1); end
            tick();
        end
        fl.id_valid = '0;
        checks++;
        if (fl.id_ready !== 1'b0) begin errors++; $display("FAIL %s_empty: got %0b expected 0", name, fl.id_ready); end
        $display("%s: handed out 32..63, ready=%0b", name, fl.id_ready);
    endtask

    task automatic test_enqueue;
        logic [5:0] e0, e1;
        fl.rrf_valid    = 2'b10;
        fl.stale_idx[0] = 6'd9;
        fl.stale_idx[1] = 6'd5;
        tick();
        checks++;
        if (fl.id_ready !== 1'b0) begin errors++; $display("FAIL enq_one_ready: got %0b expected 0", fl.id_ready); end
        fl.rrf_valid    = 2'b01;
        fl.stale_idx[0] = 6'd7;
        fl.stale_idx[1] = 6'd11;
        tick();
        fl.rrf_valid = '0;
        e0 = 6'd5;
        e1 = 6'd7;
        checks++;
        if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL enq_two_ready: got %0b expected 1", fl.id_ready); end
        checks++;
        if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL enq_idx0: got %0d expected %0d", fl.free_idx[0], e0); end
        checks++;
        if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL enq_idx1: got %0d expected %0d", fl.free_idx[1], e1); end
        $display("test_enqueue: idx={%0d,%0d}", fl.free_idx[0], fl.free_idx[1]);
    endtask

    task automatic test_simultaneous;
        logic [5:0] e0, e1;
        fl.rrf_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            fl.stale_idx[0] = 6'(40 + 2 * j);
            fl.stale_idx[1] = 6'(41 + 2 * j);
            tick();
        end
        fl.rrf_valid = '0;
        e0 = 6'd5;
        e1 = 6'd7;
        checks++;
        if (fl.free_idx[0] !== e0 || fl.free_idx[1] !== e1) begin
            errors++;
            $display("FAIL sim_pre: got {%0d,%0d} expected {%0d,%0d}", fl.free_idx[0], fl.free_idx[1], e0, e1);
        end
        fl.id_valid     = 2'b11;
        fl.rrf_valid    = 2'b11;
        fl.stale_idx[0] = 6'd50;
        fl.stale_idx[1] = 6'd51;
        tick();
        fl.rrf_valid = '0;
        for (int j = 0; j < 5; j++) begin
            e0 = (j < 4) ? 6'(40 + 2 * j) : 6'd50;
            e1 = e0 + 6'd1;
            checks++;
            if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL sim_ready j=%0d: got %0b expected 1", j, fl.id_ready); end
            checks++;
            if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL sim_idx0 j=%0d: got %0d expected %0d", j, fl.free_idx[0], e0); end
            checks++;
            if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL sim_idx1 j=%0d: got %0d expected %0d", j, fl.free_idx[1], e1); end
            tick();
        end
        fl.id_valid = '0;
        checks++;
        if (fl.id_ready !== 1'b0) begin errors++; $display("FAIL sim_empty: got %0b expected 0", fl.id_ready); end
        $display("test_simultaneous: count held at 10, returns followed existing entries");
    endtask

    task automatic test_flush;
        logic [5:0] e0, e1;
        test_reset();
        fl.id_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            e0 = 6'(32 + 2 * c);
            e1 = 6'(33 + 2 * c);
            checks++;
            if (fl.free_idx[0] !== e0 || fl.free_idx[1] !== e1) begin
                errors++;
                $display("FAIL flush_alloc c=%0d: got {%0d,%0d} expected {%0d,%0d}", c, fl.free_idx[0], fl.free_idx[1], e0, e1);
            end
            tick();
        end
        fl.id_valid     = '0;
        fl.rrf_valid    = 2'b11;
        fl.stale_idx[0] = 6'd3;
        fl.stale_idx[1] = 6'd4;
        tick();
        fl.rrf_valid = '0;
        fl.flush     = 1'b1;
        tick();
        fl.flush    = 1'b0;
        fl.id_valid = 2'b11;
        for (int c = 0; c < 16; c++) begin
            e0 = (c < 15) ? 6'(34 + 2 * c) : 6'd3;
            e1 = (c < 15) ? 6'(35 + 2 * c) : 6'd4;
            checks++;
            if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready c=%0d: got %0b expected 1", c, fl.id_ready); end
            checks++;
            if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL flush_idx0 c=%0d: got %0d expected %0d", c, fl.free_idx[0], e0); end
            checks++;
            if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL flush_idx1 c=%0d: got %0d expected %0d", c, fl.free_idx[1], e1); end
            tick();
        end
        fl.id_valid = '0;
        checks++;
        if (fl.id_ready !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0b expected 0", fl.id_ready); end
        $display("test_flush: free set 34..63,3,4 recovered");
    endtask

    task automatic test_wrap;
        logic [5:0] e0, e1;
        test_reset();
        fl.id_valid     = 2'b01;
        fl.rrf_valid    = 2'b01;
        fl.stale_idx[0] = 6'd20;
        tick();
        fl.rrf_valid = '0;
        fl.id_valid  = 2'b11;
        for (int c = 0; c < 15; c++) begin
            e0 = 6'(33 + 2 * c);
            e1 = 6'(34 + 2 * c);
            checks++;
            if (fl.free_idx[0] !== e0 || fl.free_idx[1] !== e1) begin
                errors++;
                $display("FAIL wrap_walk c=%0d: got {%0d,%0d} expected {%0d,%0d}", c, fl.free_idx[0], fl.free_idx[1], e0, e1);
            end
            tick();
        end
        e0 = 6'd63;
        e1 = 6'd20;
        checks++;
        if (fl.id_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b expected 1", fl.id_ready); end
        checks++;
        if (fl.free_idx[0] !== e0) begin errors++; $display("FAIL wrap_idx0: got %0d expected %0d", fl.free_idx[0], e0); end
        checks++;
        if (fl.free_idx[1] !== e1) begin errors++; $display("FAIL wrap_idx1: got %0d expected %0d", fl.free_idx[1], e1); end
        tick();
        fl.id_valid = '0;
        checks++;
        if (fl.id_ready !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0b expected 0", fl.id_ready); end
        $display("test_wrap: straddle read {%0d,%0d} then empty", e0, e1);
    endtask

    task automatic test_reset_priority;
        fl.flush        = 1'b1;
        fl.rrf_valid    = 2'b11;
        fl.stale_idx[0] = 6'd9;
        fl.stale_idx[1] = 6'd10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        test_drain("rst_prio");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_drain("drain");
        test_enqueue();
        test_simultaneous();
        test_flush();
        test_wrap();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
